// File: rtl/therm_code_gen.sv
// Binary-to-thermometer code generator with a direct decode port and a
// ramp/triangle sweep sequencer for encoder self-test loopback.
module therm_code_gen #(
  parameter int N_BITS  = 3,
  parameter int DWELL_W = 8,
  localparam int TW     = (1 << N_BITS) - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_BITS-1:0]  in_code,
  output logic [TW-1:0]      therm,
  output logic [N_BITS-1:0]  code_out,
  output logic               busy,
  output logic               sweep_done,
  output logic [1:0]         state_dbg
);

  // Handshake: a direct code transfers on a clk edge where in_valid & in_ready;
  // in_ready depends only on current state and mode, never on in_valid.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [N_BITS-1:0] CODE_MAX = '1;

  state_t               state_q, state_d;
  logic [N_BITS-1:0]    code_q, code_d;
  logic [TW-1:0]        therm_q, therm_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 tri_q, tri_d;

  function automatic logic [TW-1:0] decode(input logic [N_BITS-1:0] c);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < TW; i++) begin
      t[i] = (i < int'(c));
    end
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      therm_q <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      tri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      therm_q <= therm_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      tri_q   <= tri_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    tri_d   = tri_q;
    case (state_q)
      S_IDLE: begin
        if (mode == 2'd0) begin
          if (in_valid) code_d = in_code;
        end else if ((mode == 2'd1 || mode == 2'd2) && start) begin
          state_d = S_UP;
          code_d  = '0;
          cnt_d   = dwell;
          dwell_d = dwell;
          tri_d   = (mode == 2'd2);
        end
      end
      S_UP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (code_q != CODE_MAX) begin
          code_d = code_q + 1'b1;
          cnt_d  = dwell_q;
        end else if (tri_q) begin
          state_d = S_DOWN;
          code_d  = CODE_MAX - 1'b1;
          cnt_d   = dwell_q;
        end else begin
          state_d = S_DONE;
          code_d  = '0;
        end
      end
      S_DOWN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (code_q != '0) begin
          code_d = code_q - 1'b1;
          cnt_d  = dwell_q;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        code_d  = '0;
      end
    endcase
    // Register the decoded word so therm changes only on clk edges.
    therm_d = decode(code_d);
  end

  always_comb begin
    in_ready   = (state_q == S_IDLE) && (mode == 2'd0);
    busy       = (state_q == S_UP) || (state_q == S_DOWN);
    sweep_done = (state_q == S_DONE);
    therm      = therm_q;
    code_out   = code_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_therm_code_gen.sv
// Self-checking bench for therm_code_gen: decode table, randomized direct
// codes and sweeps against a code-sequence model, and reset/ignore corners.
module tb_therm_code_gen;
  localparam int NB = 3;
  localparam int TW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, in_ready, busy, sweep_done;
  logic [1:0]    mode, state_dbg;
  logic [DW-1:0] dwell;
  logic [NB-1:0] in_code, code_out;
  logic [TW-1:0] therm;

  int total = 0;
  int bad   = 0;
  logic [NB-1:0] exp_q[$];

  typedef struct {
    logic [NB-1:0] code;
    logic [TW-1:0] exp_therm;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  therm_code_gen #(.N_BITS(NB), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start(start), .dwell(dwell),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .therm(therm), .code_out(code_out), .busy(busy),
    .sweep_done(sweep_done), .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] therm_of(input int c);
    return TW'((1 << c) - 1);
  endfunction

  // Encoder model for loopback: count of ones must match code_out, no bubbles.
  task automatic check_loopback();
    int ones;
    ones = $countones(therm);
    check("loopback_popcount", ones, code_out);
    check("loopback_no_bubble", therm, therm_of(ones));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic run_sweep(input logic [1:0] m, input logic [DW-1:0] d, input bit disturb);
    logic [NB-1:0] c;
    exp_q.delete();
    for (int k = 0; k < 8; k++) repeat (int'(d) + 1) exp_q.push_back(NB'(k));
    if (m == 2'd2)
      for (int k = 6; k >= 0; k--) repeat (int'(d) + 1) exp_q.push_back(NB'(k));
    mode = m; dwell = d; start = 1'b1;
    step();
    start = 1'b0;
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      check("sweep_code", code_out, c);
      check("sweep_therm", therm, therm_of(int'(c)));
      check("sweep_busy", busy, 1);
      check("sweep_done_low", sweep_done, 0);
      check_loopback();
      if (disturb) begin
        start = 1'b1; in_valid = 1'b1; in_code = 3'd5; dwell = 8'd0;
        #1;
        check("sweep_in_ready", in_ready, 0);
      end
      if (exp_q.size() == 0) begin
        start = 1'b0; in_valid = 1'b0;
      end
      step();
    end
    check("done_pulse", sweep_done, 1);
    check("done_therm", therm, 0);
    check("done_code", code_out, 0);
    check("done_busy", busy, 0);
    step();
    check("done_single", sweep_done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    logic [NB-1:0] last;
    bit found;
    rst = 1'b0; mode = 2'd0; start = 1'b0; dwell = '0; in_valid = 1'b0; in_code = '0;

    vecs[0] = '{3'd0, 7'h00}; vecs[1] = '{3'd1, 7'h01};
    vecs[2] = '{3'd2, 7'h03}; vecs[3] = '{3'd3, 7'h07};
    vecs[4] = '{3'd4, 7'h0F}; vecs[5] = '{3'd5, 7'h1F};
    vecs[6] = '{3'd6, 7'h3F}; vecs[7] = '{3'd7, 7'h7F};

    // Reset state
    do_reset(2);
    check("rst_therm", therm, 0);
    check("rst_code", code_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", sweep_done, 0);

    // Direct decode table, back-to-back
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_code = vecs[i].code;
      #1;
      check("direct_in_ready", in_ready, 1);
      step();
      check("direct_therm", therm, vecs[i].exp_therm);
      check("direct_code", code_out, vecs[i].code);
    end
    in_valid = 1'b0;

    // Randomized direct traffic: code holds without a handshake
    last = code_out;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_code  = NB'($urandom_range(0, 7));
      if (in_valid) last = in_code;
      step();
      check("rand_direct_code", code_out, last);
      check("rand_direct_therm", therm, therm_of(int'(last)));
    end
    in_valid = 1'b0;

    // Mode 0: start with in_valid -> code accepted, no sweep
    mode = 2'd0; start = 1'b1; in_valid = 1'b1; in_code = 3'd6;
    step();
    start = 1'b0; in_valid = 1'b0;
    check("m0_start_code", code_out, 6);
    check("m0_start_busy", busy, 0);

    // Mode 3: start ignored, in_ready low
    mode = 2'd3; start = 1'b1; in_valid = 1'b1; in_code = 3'd1;
    #1;
    check("m3_in_ready", in_ready, 0);
    step();
    start = 1'b0; in_valid = 1'b0;
    check("m3_busy", busy, 0);
    check("m3_code_hold", code_out, 6);

    // Directed sweeps
    run_sweep(2'd1, 8'd0, 1'b0);
    run_sweep(2'd2, 8'd2, 1'b0);
    run_sweep(2'd1, 8'd3, 1'b1);
    run_sweep(2'd1, 8'd1, 1'b0);
    run_sweep(2'd1, 8'd255, 1'b0);

    // Randomized sweeps
    for (int i = 0; i < 4; i++)
      run_sweep(2'($urandom_range(1, 2)), DW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));

    // Reset mid-sweep at code 5
    mode = 2'd2; dwell = 8'd4; start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (code_out == 3'd5) found = 1'b1;
      else step();
    end
    check("midrst_reach_code5", found, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_therm", therm, 0);
    check("midrst_code", code_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", sweep_done, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_done", sweep_done, 0);
    end
    mode = 2'd0; in_valid = 1'b1; in_code = 3'd2;
    step();
    in_valid = 1'b0;
    check("midrst_direct_therm", therm, 7'h03);
    check("midrst_direct_code", code_out, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
